// File: rtl/dlx_pkg.sv
// Shared writeback-path types: result kinds, datapath widths and the FIFO entry layout.
package dlx_pkg;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef enum logic [2:0] {
    K_ALU = 3'd0,
    K_LB  = 3'd1,
    K_LBU = 3'd2,
    K_LH  = 3'd3,
    K_LHU = 3'd4,
    K_LW  = 3'd5
  } kind_e;

  typedef struct packed {
    logic [XLEN-1:0] val;
    logic [REGW-1:0] rd;
    logic            wr;
  } wb_ent_t;
endpackage

// File: rtl/load_align.sv
// Result formatter: picks ALU data or a big-endian load lane and extends it.
module load_align
  import dlx_pkg::*;
(
  input  logic [2:0]      kind_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic [XLEN-1:0] mem_i,
  output logic [XLEN-1:0] value_o,
  output logic            flag_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Byte 0 of the address is the most significant byte of the word.
    case (addr_lo_i)
      2'd0:    byte_sel = mem_i[31:24];
      2'd1:    byte_sel = mem_i[23:16];
      2'd2:    byte_sel = mem_i[15:8];
      default: byte_sel = mem_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? mem_i[15:0] : mem_i[31:16];

    value_o = '0;
    flag_o  = 1'b1;
    case (kind_i)
      K_ALU:   value_o = alu_i;
      K_LB:    value_o = {{24{byte_sel[7]}}, byte_sel};
      K_LBU:   value_o = {24'd0, byte_sel};
      K_LH:    value_o = {{16{half_sel[15]}}, half_sel};
      K_LHU:   value_o = {16'd0, half_sel};
      K_LW:    value_o = mem_i;
      default: flag_o  = 1'b0;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: 2-entry result FIFO feeding the regfile write port, with
// pending-register scoreboard and a retired-write counter.
module wb_stage
  import dlx_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [REGW-1:0] in_rd,
  input  logic [2:0]      in_kind,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_mem,
  input  logic [1:0]      in_addr_lo,
  input  logic            hold,
  output logic [REGW-1:0] Rd,
  output logic [XLEN-1:0] reg_s,
  output logic [XLEN-1:0] pending,
  output logic [XLEN-1:0] retired
);
  wb_ent_t         fifo_q [2];
  logic            rd_ptr_q, wr_ptr_q;
  logic [1:0]      count_q, count_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic [XLEN-1:0] reg_s_q, reg_s_d;
  logic [XLEN-1:0] retired_q, retired_d;
  logic [XLEN-1:0] fmt_val;
  logic            fmt_flag;
  logic            push, pop;
  wb_ent_t         push_ent, head;

  load_align u_align (
    .kind_i   (in_kind),
    .addr_lo_i(in_addr_lo),
    .alu_i    (in_alu),
    .mem_i    (in_mem),
    .value_o  (fmt_val),
    .flag_o   (fmt_flag)
  );

  assign in_ready = (count_q != 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != 2'd0) && !hold;
  assign head     = fifo_q[rd_ptr_q];

  always_comb begin
    push_ent.val = fmt_val;
    push_ent.rd  = in_rd;
    push_ent.wr  = fmt_flag && (in_rd != '0);
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;

    // Idle cycles write r0 with zero so the regfile bypass keeps r0 reading 0.
    rd_d      = '0;
    reg_s_d   = '0;
    retired_d = retired_q;
    if (pop && head.wr) begin
      rd_d      = head.rd;
      reg_s_d   = head.val;
      retired_d = retired_q + 32'd1;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < 2; i++) begin
      if ((count_q == 2'd2 || (count_q == 2'd1 && rd_ptr_q == 1'(i))) && fifo_q[i].wr)
        pending[fifo_q[i].rd] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_q      <= '0;
      reg_s_q   <= '0;
      retired_q <= '0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_q ^ pop;
      wr_ptr_q  <= wr_ptr_q ^ push;
      rd_q      <= rd_d;
      reg_s_q   <= reg_s_d;
      retired_q <= retired_d;
    end
  end

  // Entry storage needs no reset; validity is carried by count/pointers.
  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wr_ptr_q] <= push_ent;
  end

  assign Rd      = rd_q;
  assign reg_s   = reg_s_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table-driven formatter vectors plus
// hold, reset and counter-wrap sequences, checked against a queue scoreboard.
module tb_wb_stage;
  import dlx_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, hold;
  logic [4:0]  in_rd, Rd;
  logic [2:0]  in_kind;
  logic [31:0] in_alu, in_mem, reg_s, pending, retired;
  logic [1:0]  in_addr_lo;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_kind(in_kind), .in_alu(in_alu), .in_mem(in_mem),
    .in_addr_lo(in_addr_lo), .hold(hold), .Rd(Rd), .reg_s(reg_s),
    .pending(pending), .retired(retired)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [1:0]  lo;
    logic [31:0] exp_val;
    logic        exp_wr;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic        wr;
  } ent_t;

  ent_t        mq[$];
  vec_t        tbl[16];
  vec_t        nv, va, vb;
  logic [4:0]  exp_rd;
  logic [31:0] exp_val, exp_ret;
  int          nvec = 0;
  int          nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the scoreboard across the edge, then compare.
  task automatic step(input vec_t v, input bit valid, input bit hld, input bit rst, input string tag);
    ent_t        e;
    bit          do_push, do_pop;
    logic [31:0] pend;
    in_valid = valid; in_kind = v.kind; in_rd = v.rd; in_alu = v.alu;
    in_mem = v.mem; in_addr_lo = v.lo; hold = hld; reset = rst;
    do_push = valid && (mq.size() != 2) && !rst;
    do_pop  = (mq.size() != 0) && !hld && !rst;
    @(posedge clk);
    exp_rd = '0; exp_val = '0;
    if (rst) begin
      mq.delete();
      exp_ret = '0;
    end else begin
      if (do_pop) begin
        e = mq.pop_front();
        if (e.wr) begin exp_rd = e.rd; exp_val = e.val; exp_ret = exp_ret + 32'd1; end
      end
      if (do_push) begin
        e.rd = v.rd; e.val = v.exp_val; e.wr = v.exp_wr;
        mq.push_back(e);
      end
    end
    @(negedge clk);
    pend = '0;
    foreach (mq[i]) if (mq[i].wr) pend[mq[i].rd] = 1'b1;
    check($sformatf("%s Rd", tag),       {27'd0, Rd}, {27'd0, exp_rd});
    check($sformatf("%s reg_s", tag),    reg_s, exp_val);
    check($sformatf("%s retired", tag),  retired, exp_ret);
    check($sformatf("%s pending", tag),  pending, pend);
    check($sformatf("%s in_ready", tag), {31'd0, in_ready}, {31'd0, mq.size() != 2});
  endtask

  initial begin
    nv = '{3'd7, 5'd0, 32'd0, 32'd0, 2'd0, 32'd0, 1'b0};
    tbl[0]  = '{K_LB,  5'd3,  32'h0,        32'h12F45678, 2'd1, 32'hFFFFFFF4, 1'b1};
    tbl[1]  = '{K_LHU, 5'd7,  32'h0,        32'h8001ABCD, 2'd2, 32'h0000ABCD, 1'b1};
    tbl[2]  = '{K_LH,  5'd7,  32'h0,        32'h8001ABCD, 2'd0, 32'hFFFF8001, 1'b1};
    tbl[3]  = '{K_ALU, 5'd0,  32'hDEADBEEF, 32'h0,        2'd0, 32'h0,        1'b0};
    tbl[4]  = '{K_LBU, 5'd1,  32'h0,        32'h12F45678, 2'd1, 32'h000000F4, 1'b1};
    tbl[5]  = '{K_LB,  5'd2,  32'h0,        32'h12F45678, 2'd0, 32'h00000012, 1'b1};
    tbl[6]  = '{K_LB,  5'd4,  32'h0,        32'h12F45678, 2'd3, 32'h00000078, 1'b1};
    tbl[7]  = '{K_LB,  5'd6,  32'h0,        32'h00000080, 2'd3, 32'hFFFFFF80, 1'b1};
    tbl[8]  = '{K_LW,  5'd31, 32'h0,        32'h8001ABCD, 2'd3, 32'h8001ABCD, 1'b1};
    tbl[9]  = '{K_LH,  5'd8,  32'h0,        32'h8001ABCD, 2'd1, 32'hFFFF8001, 1'b1};
    tbl[10] = '{K_LHU, 5'd9,  32'h0,        32'h8001ABCD, 2'd3, 32'h0000ABCD, 1'b1};
    tbl[11] = '{3'd7,  5'd4,  32'h11111111, 32'h22222222, 2'd0, 32'h0,        1'b0};
    tbl[12] = '{3'd6,  5'd4,  32'h11111111, 32'h22222222, 2'd0, 32'h0,        1'b0};
    tbl[13] = '{K_ALU, 5'd10, 32'h12345678, 32'hFFFFFFFF, 2'd3, 32'h12345678, 1'b1};
    tbl[14] = '{K_LBU, 5'd11, 32'h0,        32'h12F45678, 2'd2, 32'h00000056, 1'b1};
    tbl[15] = '{K_LW,  5'd0,  32'h0,        32'hCAFEF00D, 2'd0, 32'h0,        1'b0};
    exp_ret = '0;

    step(nv, 1'b0, 1'b0, 1'b1, "reset");
    step(nv, 1'b0, 1'b0, 1'b0, "post-reset");

    // Isolated pushes: each write must appear one cycle after its push.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i], 1'b1, 1'b0, 1'b0, $sformatf("iso%0d push", i));
      step(nv,     1'b0, 1'b0, 1'b0, $sformatf("iso%0d drain", i));
    end
    // Back-to-back: push at count 1 while the head drains.
    for (int i = 0; i < 16; i++)
      step(tbl[i], 1'b1, 1'b0, 1'b0, $sformatf("b2b%0d", i));
    step(nv, 1'b0, 1'b0, 1'b0, "b2b tail");

    // Hold: fill to 2, offer a third that must be refused, then release.
    va = '{K_LW, 5'd5, 32'h0, 32'hA5A5A5A5, 2'd0, 32'hA5A5A5A5, 1'b1};
    vb = '{K_ALU, 5'd9, 32'h99999999, 32'h0, 2'd0, 32'h99999999, 1'b1};
    step(va, 1'b1, 1'b1, 1'b0, "hold push r5");
    step(vb, 1'b1, 1'b1, 1'b0, "hold push r9");
    step(tbl[0], 1'b1, 1'b1, 1'b0, "hold full refuse");
    for (int i = 0; i < 4; i++) step(nv, 1'b0, 1'b1, 1'b0, $sformatf("hold%0d", i));
    step(nv, 1'b0, 1'b0, 1'b0, "release r5");
    step(nv, 1'b0, 1'b0, 1'b0, "release r9");
    step(nv, 1'b0, 1'b0, 1'b0, "release idle");

    // Reset with two entries queued and a push offered: everything discarded.
    step(va, 1'b1, 1'b1, 1'b0, "prerst push r5");
    step(vb, 1'b1, 1'b1, 1'b0, "prerst push r9");
    step(tbl[1], 1'b1, 1'b0, 1'b1, "reset full");
    step(nv, 1'b0, 1'b0, 1'b0, "after reset");

    // Counter wrap from 0xFFFFFFFF.
    force dut.retired_q = 32'hFFFFFFFF;
    #1 release dut.retired_q;
    exp_ret = 32'hFFFFFFFF;
    check("retired preload", retired, exp_ret);
    step(tbl[13], 1'b1, 1'b0, 1'b0, "wrap push");
    step(nv, 1'b0, 1'b0, 1'b0, "wrap drain");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  in  1  rising-edge clock; all state updates on posedge clk.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  upstream (MEM stage) result valid.
REQ-004 in_ready  out  1  stage can accept a result this cycle.
REQ-005 in_rd  in  5  destination register number.
REQ-006 in_kind  in  3  result kind: ALU, LB, LBU, LH, LHU, LW; other codes mean no write.
REQ-007 in_alu  in  32  ALU/link result.
REQ-008 in_mem  in  32  raw big-endian memory word.
REQ-009 in_addr_lo  in  2  load address bits [1:0].
REQ-010 hold  in  1  regfile write port stolen this cycle; no drain.
REQ-011 Rd  out  5  register-file write index, registered.
REQ-012 reg_s  out  32  register-file write data, registered.
REQ-013 pending  out  32  bit i set while a queued entry targets register i; bit 0 is always 0.
REQ-014 retired  out  32  count of drained non-r0 writes, wraps.

Function
REQ-015 Input transfer occurs when in_valid && in_ready.
REQ-016 Buffer is a 2-entry FIFO; in_ready = (count != 2), with no same-cycle bypass when full.
REQ-017 Each accepted entry is formatted at push and stored as the formatted value, rd, and a write flag.
REQ-018 ALU kind stores in_alu unchanged.
REQ-019 LW stores in_mem and ignores in_addr_lo.
REQ-020 LB/LBU select a byte big-endian: lo=0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
REQ-021 LB sign-extends the selected byte; LBU zero-extends it.
REQ-022 LH/LHU select a halfword: addr_lo[1]=0 -> [31:16], else [15:0]; addr_lo[0] is ignored.
REQ-023 LH sign-extends the selected halfword; LHU zero-extends it.
REQ-024 Entries with an undefined kind, or with in_rd=0, are stored with the write flag clear.
REQ-025 Drain: when the FIFO is non-empty and hold=0, pop the head at the posedge.
REQ-026 On drain of a flagged entry, Rd and reg_s take the entry's rd and value.
REQ-027 On drain of an unflagged entry, Rd and reg_s take 0.
REQ-028 In any cycle without a drain, Rd and reg_s are 0 (the regfile writes every cycle; r0 with data 0 is the idle write and keeps r0 bypass reading 0).
REQ-029 Latency is 1 cycle: an entry pushed at edge N into an empty FIFO with hold=0 appears on Rd/reg_s after edge N+1.
REQ-030 Simultaneous push and pop are allowed at count 1 (count stays 1, order preserved) and at count 2 is impossible by REQ-016.
REQ-031 Pop at count 0 never occurs.
REQ-032 pending is the OR of decoded rd over valid, flagged FIFO entries and is combinational from FIFO state.
REQ-033 pending drops in the same cycle Rd/reg_s present the write, so the regfile bypass covers the handoff.
REQ-034 retired increments by 1 on each flagged drain and wraps 0xFFFFFFFF -> 0.
REQ-035 hold held high for many cycles keeps FIFO contents and pending stable; the FIFO fills to 2 and in_ready drops.

Reset
REQ-036 reset clears count, FIFO pointers and retired, and sets Rd=0, reg_s=0, so pending=0 and in_ready=1 in the next cycle.
REQ-037 reset has priority over push, pop and hold in the same cycle.
REQ-038 An entry in flight at reset is discarded, with no write on the following cycle.

Structure
REQ-039 A shared package dlx_pkg holds the in_kind enum, the 32-bit width constant and the 5-bit register-index width.
REQ-040 The formatter (kind, addr_lo, alu, mem -> value, flag) is a combinational sub-module named load_align.
REQ-041 FIFO, drain and counter logic live in wb_stage; total implementation is 120-400 lines.

Verification
REQ-042 Push LB, rd=3, mem=0x12F45678, lo=1 -> next cycle Rd=3, reg_s=0xFFFFFFF4, retired=1.
REQ-043 Push LHU, rd=7, mem=0x8001ABCD, lo=2 -> reg_s=0x0000ABCD; LH with lo=0 -> 0xFFFF8001.
REQ-044 Push ALU rd=0, data 0xDEADBEEF -> Rd=0, reg_s=0, retired unchanged, pending stays 0.
REQ-045 hold=1, push rd=5 then rd=9 -> in_ready=0, pending=0x00000220; release hold -> writes to r5 then r9 on consecutive cycles, pending clears bit by bit.
REQ-046 Push at count 1 while draining -> order preserved, count stays 1; reset asserted with 2 entries queued -> next cycle Rd=0, reg_s=0, pending=0, in_ready=1.
REQ-047 Preload retired=0xFFFFFFFF via 2^32-1 drains (or a force) then one flagged drain -> retired=0.
